prewrap_host_seq: RTL and testbench

- Host-side initiator for the prewrapper's register interface: drives the rd/wr address and message buses, and consumes read data.
- Turns one front-end request into a fixed bus transaction sequence:
  - write the DUT input vector;
  - issue a run command;
  - poll status until done or timeout;
  - read the DUT output;
  - optionally read the scan-dump words.
- Sits between a testbench/CPU-side request source and the prewrapped design. Results are returned on a valid/ready response stream.

---
 rtl/prewrap_host_pkg.sv | 38 +++
 rtl/prewrap_host_seq_rd_port.sv | 58 +++++
 rtl/prewrap_host_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_prewrap_host_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prewrap_host_pkg.sv
// Shared register map, command/status encodings and sequencer state for the
// prewrapper host-side initiator.
package prewrap_host_pkg;

  localparam logic [31:0] ADDR_NOP    = 32'd0;
  localparam logic [31:0] ADDR_CMD    = 32'd1;
  localparam logic [31:0] ADDR_DIN    = 32'd2;
  localparam logic [31:0] ADDR_STATUS = 32'd3;
  localparam logic [31:0] ADDR_DOUT   = 32'd4;
  localparam logic [31:0] ADDR_DFT    = 32'd16;

  localparam logic [31:0] CMD_RUN   = 32'd1;
  localparam logic [31:0] CMD_DUMP  = 32'd2;
  localparam logic [31:0] CMD_CLEAR = 32'd4;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_ERR  = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrDin,
    StWrGap1,
    StWrCmd,
    StWrGap2,
    StPoll,
    StRdDout,
    StResp,
    StRdDft,
    StErr,
    StWrClr,
    StClrGap
  } host_state_e;

  function automatic logic [31:0] dft_addr(input logic [3:0] idx);
    return ADDR_DFT + {28'd0, idx};
  endfunction

endpackage

// File: rtl/prewrap_host_seq_rd_port.sv
// Read port: presents a read address for RD_LAT cycles and flags the last
// cycle, in which the prewrapper's read data is valid.
module prewrap_rd_port
  import prewrap_host_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  output logic [31:0] axi_rd_addr_o,
  input  logic [31:0] axi_rd_msg_i,
  output logic        done_o,
  output logic [31:0] data_o
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;

  assign done_o        = busy_q && (cnt_q == '0);
  assign data_o        = axi_rd_msg_i;
  assign axi_rd_addr_o = addr_q;

  // A new start in the done cycle chains reads back to back.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(RD_LAT - 1);
      addr_d = addr_i;
    end else if (done_o) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      addr_d = ADDR_NOP;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= ADDR_NOP;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/prewrap_host_seq.sv
// Host-side sequencer: turns one request into DIN write, run command, status
// polling, DOUT read and optional scan-dump reads, returning words on a stream.
module prewrap_host_seq
  import prewrap_host_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned DUMP_WORDS = 1,
  parameter int unsigned POLL_MAX   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_din,
  input  logic        req_dump,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_is_dft,
  output logic        resp_last,
  output logic        resp_err,
  output logic [31:0] axi_rd_addr,
  output logic [31:0] axi_wr_addr,
  output logic [31:0] axi_wr_msg,
  input  logic [31:0] axi_rd_msg
);

  localparam int unsigned PollW   = $clog2(POLL_MAX + 1);
  localparam logic [3:0]  LastIdx = 4'(DUMP_WORDS - 1);

  host_state_e      state_q, state_d;
  logic [31:0]      din_q, din_d;
  logic             dump_q, dump_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [3:0]       word_idx_q, word_idx_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_is_dft_q, resp_is_dft_d;
  logic        resp_last_q, resp_last_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_msg_q, wr_msg_d;

  logic        rd_start;
  logic [31:0] rd_start_addr;
  logic        rd_done;
  logic [31:0] rd_data;

  prewrap_rd_port #(
    .RD_LAT(RD_LAT)
  ) u_rd_port (
    .clk_i        (clk),
    .rst_i        (reset),
    .start_i      (rd_start),
    .addr_i       (rd_start_addr),
    .axi_rd_addr_o(axi_rd_addr),
    .axi_rd_msg_i (axi_rd_msg),
    .done_o       (rd_done),
    .data_o       (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    din_d         = din_q;
    dump_d        = dump_q;
    poll_cnt_d    = poll_cnt_q;
    word_idx_d    = word_idx_q;
    resp_data_d   = resp_data_q;
    resp_is_dft_d = resp_is_dft_q;
    resp_last_d   = resp_last_q;
    resp_err_d    = resp_err_q;
    rd_start      = 1'b0;
    rd_start_addr = ADDR_NOP;

    unique case (state_q)
      StIdle: begin
        poll_cnt_d = '0;
        word_idx_d = '0;
        if (req_valid && req_ready_q) begin
          din_d   = req_din;
          dump_d  = req_dump;
          state_d = StWrDin;
        end
      end
      StWrDin:  state_d = StWrGap1;
      StWrGap1: state_d = StWrCmd;
      StWrCmd:  state_d = StWrGap2;
      StWrGap2: begin
        rd_start      = 1'b1;
        rd_start_addr = ADDR_STATUS;
        state_d       = StPoll;
      end
      StPoll: begin
        if (rd_done) begin
          // An error status still finishes the run; the output is read as usual.
          if (rd_data[STAT_DONE] || rd_data[STAT_ERR]) begin
            rd_start      = 1'b1;
            rd_start_addr = ADDR_DOUT;
            state_d       = StRdDout;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_d == PollW'(POLL_MAX)) begin
              resp_data_d   = '0;
              resp_is_dft_d = 1'b0;
              resp_last_d   = 1'b1;
              resp_err_d    = 1'b1;
              state_d       = StErr;
            end else begin
              rd_start      = 1'b1;
              rd_start_addr = ADDR_STATUS;
            end
          end
        end
      end
      StRdDout: begin
        if (rd_done) begin
          resp_data_d   = rd_data;
          resp_is_dft_d = 1'b0;
          resp_last_d   = !dump_q;
          resp_err_d    = 1'b0;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          if (resp_last_q) begin
            state_d = StWrClr;
          end else begin
            if (resp_is_dft_q) begin
              word_idx_d = word_idx_q + 1'b1;
            end
            rd_start      = 1'b1;
            rd_start_addr = dft_addr(word_idx_d);
            state_d       = StRdDft;
          end
        end
      end
      StRdDft: begin
        if (rd_done) begin
          resp_data_d   = rd_data;
          resp_is_dft_d = 1'b1;
          resp_last_d   = (word_idx_q == LastIdx);
          resp_err_d    = 1'b0;
          state_d       = StResp;
        end
      end
      StErr: begin
        if (resp_ready) begin
          state_d = StWrClr;
        end
      end
      StWrClr:  state_d = StClrGap;
      StClrGap: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state presents.
    req_ready_d  = (state_d == StIdle);
    resp_valid_d = (state_d == StResp) || (state_d == StErr);
    if (!resp_valid_d) begin
      resp_data_d   = '0;
      resp_is_dft_d = 1'b0;
      resp_last_d   = 1'b0;
      resp_err_d    = 1'b0;
    end

    wr_addr_d = ADDR_NOP;
    wr_msg_d  = '0;
    case (state_d)
      StWrDin: begin
        wr_addr_d = ADDR_DIN;
        wr_msg_d  = din_d;
      end
      StWrCmd: begin
        wr_addr_d = ADDR_CMD;
        wr_msg_d  = dump_q ? (CMD_RUN | CMD_DUMP) : CMD_RUN;
      end
      StWrClr: begin
        wr_addr_d = ADDR_CMD;
        wr_msg_d  = CMD_CLEAR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      din_q         <= '0;
      dump_q        <= 1'b0;
      poll_cnt_q    <= '0;
      word_idx_q    <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_is_dft_q <= 1'b0;
      resp_last_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      wr_addr_q     <= ADDR_NOP;
      wr_msg_q      <= '0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      dump_q        <= dump_d;
      poll_cnt_q    <= poll_cnt_d;
      word_idx_q    <= word_idx_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_is_dft_q <= resp_is_dft_d;
      resp_last_q   <= resp_last_d;
      resp_err_q    <= resp_err_d;
      wr_addr_q     <= wr_addr_d;
      wr_msg_q      <= wr_msg_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_is_dft = resp_is_dft_q;
  assign resp_last   = resp_last_q;
  assign resp_err    = resp_err_q;
  assign axi_wr_addr = wr_addr_q;
  assign axi_wr_msg  = wr_msg_q;

endmodule

// File: tb/tb_prewrap_host_seq.sv
// Bench: two sequencers (read latency 1 and 3) against a behavioural prewrapper
// and a per-request transaction model; directed steps followed by random requests.
module tb_prewrap_host_seq;

  localparam int unsigned DumpWords = 2;
  localparam int unsigned PollMax   = 4;
  localparam int unsigned LogDepth  = 512;

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [31:0] req_din     [2];
  logic        req_dump    [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] resp_data   [2];
  logic        resp_is_dft [2];
  logic        resp_last   [2];
  logic        resp_err    [2];
  logic [31:0] rd_addr     [2];
  logic [31:0] wr_addr     [2];
  logic [31:0] wr_msg      [2];
  logic [31:0] rd_msg      [2];

  always #5 clk = ~clk;

  prewrap_host_seq #(.RD_LAT(1), .DUMP_WORDS(DumpWords), .POLL_MAX(PollMax)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_din(req_din[0]), .req_dump(req_dump[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_data(resp_data[0]), .resp_is_dft(resp_is_dft[0]),
    .resp_last(resp_last[0]), .resp_err(resp_err[0]), .axi_rd_addr(rd_addr[0]),
    .axi_wr_addr(wr_addr[0]), .axi_wr_msg(wr_msg[0]), .axi_rd_msg(rd_msg[0])
  );

  prewrap_host_seq #(.RD_LAT(3), .DUMP_WORDS(DumpWords), .POLL_MAX(PollMax)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_din(req_din[1]), .req_dump(req_dump[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_data(resp_data[1]), .resp_is_dft(resp_is_dft[1]),
    .resp_last(resp_last[1]), .resp_err(resp_err[1]), .axi_rd_addr(rd_addr[1]),
    .axi_wr_addr(wr_addr[1]), .axi_wr_msg(wr_msg[1]), .axi_rd_msg(rd_msg[1])
  );

  // Behavioural prewrapper: status reports done from the n-th poll of a request on
  // (n == 0: never); before the final cycle of a read the bus carries inverted data.
  int unsigned polls_needed [2] = '{0, 0};
  int unsigned poll_base    [2] = '{0, 0};
  logic [31:0] stat_code    [2] = '{0, 0};
  logic [31:0] dout_val     [2] = '{0, 0};
  logic [31:0] dft_val      [2][DumpWords];
  int unsigned status_reads [2] = '{0, 0};
  int unsigned wr_n         [2] = '{0, 0};
  int unsigned gap_viol     [2] = '{0, 0};
  logic [31:0] wr_a         [2][LogDepth];
  logic [31:0] wr_m         [2][LogDepth];
  logic        prev_wr      [2] = '{1'b0, 1'b0};
  logic [31:0] last_addr    [2] = '{0, 0};
  int unsigned last_idx     [2] = '{0, 0};
  int unsigned cur_idx      [2];
  logic [31:0] true_msg     [2];

  always_comb begin
    int unsigned p;
    p = 0;
    for (int k = 0; k < 2; k++) begin
      p = status_reads[k] - poll_base[k] + 1;
      true_msg[k] = '0;
      if (rd_addr[k] == 32'd3) begin
        if (polls_needed[k] != 0 && p >= polls_needed[k]) true_msg[k] = stat_code[k];
      end else if (rd_addr[k] == 32'd4) begin
        true_msg[k] = dout_val[k];
      end else if (rd_addr[k] == 32'd16) begin
        true_msg[k] = dft_val[k][0];
      end else if (rd_addr[k] == 32'd17) begin
        true_msg[k] = dft_val[k][1];
      end
      cur_idx[k] = (rd_addr[k] != 0 && rd_addr[k] == last_addr[k]) ? last_idx[k] + 1 : 0;
      rd_msg[k]  = (cur_idx[k] % lat_of(k) == lat_of(k) - 1) ? true_msg[k] : ~true_msg[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_addr[k] == 32'd3 && (cur_idx[k] % lat_of(k) == lat_of(k) - 1))
        status_reads[k] <= status_reads[k] + 1;
      if (wr_addr[k] != 0) begin
        if (wr_n[k] < LogDepth) begin
          wr_a[k][wr_n[k]] <= wr_addr[k];
          wr_m[k][wr_n[k]] <= wr_msg[k];
        end
        wr_n[k] <= wr_n[k] + 1;
        if (prev_wr[k]) gap_viol[k] <= gap_viol[k] + 1;
      end
      prev_wr[k]   <= (wr_addr[k] != 0);
      last_addr[k] <= rd_addr[k];
      last_idx[k]  <= cur_idx[k];
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    for (int i = 0; i < 300 && !req_ready[k]; i++) @(negedge clk);
    check("req_ready", 64'(req_ready[k]), 64'd1);
  endtask

  task automatic wait_valid(input int k);
    for (int i = 0; i < 300 && !resp_valid[k]; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge.
  task automatic issue(input int k, input logic [31:0] din, input logic dump);
    wait_ready(k);
    req_valid[k] = 1'b1;
    req_din[k]   = din;
    req_dump[k]  = dump;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic run_req(input int k, input logic [31:0] din, input logic dump,
                         input int unsigned n, input logic [31:0] stat,
                         input logic [31:0] dout, input logic [31:0] d0,
                         input logic [31:0] d1, input int unsigned stall, input bit chk_lat);
    bit          err;
    int unsigned nresp, wn0, cyc;
    logic [31:0] ed [3];
    bit          edft [3], elast [3], eerr [3];

    err   = (n == 0 || n > PollMax);
    nresp = err ? 1 : (dump ? 1 + DumpWords : 1);
    ed[0] = err ? 32'd0 : dout;  edft[0] = 0; elast[0] = err || !dump; eerr[0] = err;
    ed[1] = d0;                  edft[1] = 1; elast[1] = 0;            eerr[1] = 0;
    ed[2] = d1;                  edft[2] = 1; elast[2] = 1;            eerr[2] = 0;

    polls_needed[k] = n;
    stat_code[k]    = stat;
    dout_val[k]     = dout;
    dft_val[k][0]   = d0;
    dft_val[k][1]   = d1;
    poll_base[k]    = status_reads[k];
    wn0             = wr_n[k];

    issue(k, din, dump);
    cyc = 1;
    while (!resp_valid[k] && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (chk_lat) check("latency", 64'(cyc), 64'(5 + 2 * lat_of(k)));

    for (int r = 0; r < int'(nresp); r++) begin
      wait_valid(k);
      check("resp_valid", 64'(resp_valid[k]), 64'd1);
      for (int s = 0; s < int'(stall); s++) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_resp", {31'd0, resp_valid[k], resp_data[k]}, {31'd0, 1'b1, ed[r]});
        check("stall_bus", {rd_addr[k], wr_addr[k]}, 64'd0);
      end
      check("resp_data", 64'(resp_data[k]), 64'(ed[r]));
      check("resp_flags", {61'd0, resp_is_dft[k], resp_last[k], resp_err[k]},
            {61'd0, edft[r], elast[r], eerr[r]});
      resp_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[k] = 1'b0;
    end

    wait_ready(k);
    check("status_reads", 64'(status_reads[k] - poll_base[k]), 64'(err ? PollMax : n));
    check("write_count", 64'(wr_n[k] - wn0), 64'd3);
    if (wr_n[k] - wn0 == 3 && wn0 + 3 <= LogDepth) begin
      check("wr_din", {wr_a[k][wn0], wr_m[k][wn0]}, {32'd2, din});
      check("wr_cmd", {wr_a[k][wn0+1], wr_m[k][wn0+1]}, {32'd1, dump ? 32'd3 : 32'd1});
      check("wr_clear", {wr_a[k][wn0+2], wr_m[k][wn0+2]}, {32'd1, 32'd4});
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k]  = 1'b0;
      req_din[k]    = '0;
      req_dump[k]   = 1'b0;
      resp_ready[k] = 1'b0;
      dft_val[k][0] = '0;
      dft_val[k][1] = '0;
    end

    #23;
    for (int k = 0; k < 2; k++) begin
      check("reset_ready", 64'(req_ready[k]), 64'd0);
      check("reset_resp", {resp_valid[k], resp_data[k], resp_is_dft[k], resp_last[k],
                           resp_err[k]}, 64'd0);
      check("reset_bus", {rd_addr[k], wr_addr[k]}, 64'd0);
      check("reset_wmsg", 64'(wr_msg[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", {req_ready[0], req_ready[1]}, 64'd3);

    // Latency-1 port: basic run, dump run, timeout, POLL_MAX boundaries, long stall.
    run_req(0, 32'hA5A5_0001, 1'b0, 1, 32'd1, 32'h0000_1234, 32'd0, 32'd0, 0, 1'b1);
    run_req(0, 32'h1111_2222, 1'b1, 1, 32'd1, 32'h0000_5678, 32'hDEAD_BEEF,
            32'h0BAD_F00D, 0, 1'b0);
    run_req(0, 32'h3333_4444, 1'b0, 0, 32'd1, 32'h0000_9999, 32'd0, 32'd0, 0, 1'b0);
    run_req(0, 32'h5555_6666, 1'b0, 4, 32'd1, 32'h0000_4444, 32'd0, 32'd0, 0, 1'b0);
    run_req(0, 32'h7777_8888, 1'b1, 5, 32'd1, 32'h0000_5555, 32'd1, 32'd2, 0, 1'b0);
    run_req(0, 32'h9999_AAAA, 1'b1, 2, 32'd1, 32'hCAFE_0001, 32'hCAFE_0002,
            32'hCAFE_0003, 20, 1'b0);

    // Latency-3 port: data only valid in the last cycle; error status counts as done.
    run_req(1, 32'h0000_0001, 1'b0, 1, 32'd1, 32'h0000_ABCD, 32'd0, 32'd0, 0, 1'b1);
    run_req(1, 32'h0000_0002, 1'b1, 3, 32'd2, 32'h1234_5678, 32'h0F0F_0F0F,
            32'hF0F0_F0F0, 1, 1'b0);
    run_req(1, 32'h0000_0003, 1'b0, 0, 32'd1, 32'h0000_0000, 32'd0, 32'd0, 0, 1'b0);

    // Asynchronous reset while polling, then a clean run.
    polls_needed[1] = 0;
    poll_base[1]    = status_reads[1];
    issue(1, 32'hBEEF_0000, 1'b1);
    for (int i = 0; i < 50 && rd_addr[1] != 32'd3; i++) @(negedge clk);
    check("reached_poll", 64'(rd_addr[1]), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("async_ready", 64'(req_ready[1]), 64'd0);
    check("async_resp", {resp_valid[1], resp_data[1], resp_is_dft[1], resp_last[1],
                         resp_err[1]}, 64'd0);
    check("async_bus", {rd_addr[1], wr_addr[1]}, 64'd0);
    check("async_wmsg", 64'(wr_msg[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_midreset", {req_ready[0], req_ready[1]}, 64'd3);
    run_req(1, 32'h2468_ACE0, 1'b0, 2, 32'd1, 32'h1357_9BDF, 32'd0, 32'd0, 0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      int          k;
      int unsigned n;
      k = int'($urandom_range(0, 1));
      n = $urandom_range(0, 6);
      run_req(k, $urandom, 1'($urandom_range(0, 1)), n, 32'($urandom_range(1, 3)),
              $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b0);
    end

    check("write_gap_0", 64'(gap_viol[0]), 64'd0);
    check("write_gap_1", 64'(gap_viol[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
